mips_datapath_pc_sequencer: RTL and testbench

//   Fetch-stage PC sequencer. Owns the architectural PC register and issues instruction fetches over a req/ack handshake.

---
 rtl/mips_datapath_pc_sequencer.sv | 173 +++++++++++++++++
 tb/tb_mips_datapath_pc_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_datapath_pc_sequencer.sv
// Fetch-stage PC sequencer.
//
// Owns the architectural PC and issues one instruction fetch at a time over a
// req/ack handshake. Fetched words land in a one-entry output register feeding
// IF/ID. Resolved PC actions from EX (Branch/Jump/JumpReg) redirect the PC,
// pulse flush and discard any fetch that the redirect made stale.
//
// Ports
//   clock, reset                 single clock, synchronous active-high reset
//   stall                        IF/ID not consuming; output register holds
//   redirectValid, action        resolved PC action (0 Inc, 1 Branch, 2 Jump, 3 JumpReg)
//   branchTarget, jumpTarget,
//   regTarget                    redirect targets, selected by action
//   memReq, memAddr              fetch request and word-aligned address
//   memAck, memData              fetch completion and returned word
//   instrValid, instr, instrPc   output register towards IF/ID
//   flush                        one-cycle pulse squashing younger IF/ID state
//   pc                           next address to fetch
module mips_datapath_pc_sequencer #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h00400000)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirectValid,
  input  logic [1:0]       action,
  input  logic [WIDTH-1:0] branchTarget,
  input  logic [WIDTH-1:0] jumpTarget,
  input  logic [WIDTH-1:0] regTarget,
  output logic             memReq,
  output logic [WIDTH-1:0] memAddr,
  input  logic             memAck,
  input  logic [31:0]      memData,
  output logic             instrValid,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] instrPc,
  output logic             flush,
  output logic [WIDTH-1:0] pc
);

  localparam logic [1:0] ActInc     = 2'd0;
  localparam logic [1:0] ActBranch  = 2'd1;
  localparam logic [1:0] ActJump    = 2'd2;
  localparam logic [1:0] ActJumpReg = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDiscard
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] addr_q;       // address of the request issued last cycle
  logic             pend_q, pend_d; // a request is outstanding without ack
  logic             instr_valid_q, instr_valid_d;
  logic [31:0]      instr_q, instr_d;
  logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic             flush_q;

  logic             redirect;
  logic [WIDTH-1:0] target_raw;
  logic [WIDTH-1:0] target;
  logic             ack;

  // Redirect decode: Inc is a no-op even when flagged valid.
  assign redirect = redirectValid && (action != ActInc);

  always_comb begin
    target_raw = branchTarget;
    unique case (action)
      ActInc:     target_raw = branchTarget;
      ActBranch:  target_raw = branchTarget;
      ActJump:    target_raw = jumpTarget;
      ActJumpReg: target_raw = regTarget;
      default:    target_raw = branchTarget;
    endcase
  end

  assign target = {target_raw[WIDTH-1:2], 2'b00};

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    state_d = StReq;
      // Once memReq is up it cannot be withdrawn, so a redirect that finds a
      // request without ack must wait out that fetch in StDiscard.
      StReq:     if (redirect && memReq && !memAck) state_d = StDiscard;
      StDiscard: if (ack) state_d = StReq;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs: fetch request and address
  always_comb begin
    memReq = 1'b0;
    unique case (state_q)
      StIdle:    memReq = 1'b0;
      // Only one request is ever outstanding, and a pending one implies the
      // output register was freed, so its ack always has somewhere to land.
      StReq:     memReq = pend_q || !instr_valid_q || !stall;
      StDiscard: memReq = 1'b1;
      default:   memReq = 1'b0;
    endcase
  end

  assign memAddr = pend_q ? addr_q : pc_q;
  assign ack     = memReq && memAck;

  // Datapath next-state
  always_comb begin
    pc_d          = pc_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    pend_d        = memReq && !ack;

    if (redirect) begin
      pc_d = target;
    end else if ((state_q == StReq) && ack) begin
      pc_d = pc_q + WIDTH'(4);
    end

    if (redirect) begin
      instr_valid_d = 1'b0;
    end else if ((state_q == StReq) && ack) begin
      instr_valid_d = 1'b1;
      instr_d       = memData;
      instr_pc_d    = memAddr;
    end else if (!stall) begin
      instr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      addr_q        <= RESET_PC;
      pend_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      flush_q       <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      addr_q        <= memAddr;
      pend_q        <= pend_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      flush_q       <= redirect;
    end
  end

  assign pc         = pc_q;
  assign instrValid = instr_valid_q;
  assign instr      = instr_q;
  assign instrPc    = instr_pc_q;
  assign flush      = flush_q;

endmodule

// File: tb/tb_mips_datapath_pc_sequencer.sv
// Directed bench for mips_datapath_pc_sequencer. Memory returns
// memAddr ^ DataKey so every delivered word identifies its own address.
module tb_mips_datapath_pc_sequencer;

  localparam logic [31:0] DataKey = 32'hC0DE0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirectValid;
  logic [1:0]  action;
  logic [31:0] branchTarget;
  logic [31:0] jumpTarget;
  logic [31:0] regTarget;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memData;
  logic        instrValid;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic        flush;
  logic [31:0] pc;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  assign memData = memAddr ^ DataKey;

  mips_datapath_pc_sequencer #(
    .WIDTH    (32),
    .RESET_PC (32'h00400000)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .redirectValid (redirectValid),
    .action        (action),
    .branchTarget  (branchTarget),
    .jumpTarget    (jumpTarget),
    .regTarget     (regTarget),
    .memReq        (memReq),
    .memAddr       (memAddr),
    .memAck        (memAck),
    .memData       (memData),
    .instrValid    (instrValid),
    .instr         (instr),
    .instrPc       (instrPc),
    .flush         (flush),
    .pc            (pc)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirectValid = 1'b0; action = 2'd0;
    branchTarget = '0; jumpTarget = '0; regTarget = '0; memAck = 1'b0;
    cyc();
    cyc();
    check("rst_memReq",     32'(memReq),     32'd0);
    check("rst_instrValid", 32'(instrValid), 32'd0);
    check("rst_flush",      32'(flush),      32'd0);
    check("rst_instr",      instr,           32'd0);
    check("rst_instrPc",    instrPc,         32'd0);
    check("rst_pc",         pc,              32'h00400000);

    // Zero-wait sequential fetch
    reset = 1'b0; memAck = 1'b1;
    cyc();
    check("seq0_req",   32'(memReq),     32'd1);
    check("seq0_addr",  memAddr,         32'h00400000);
    check("seq0_valid", 32'(instrValid), 32'd0);
    cyc();
    check("seq1_addr",   memAddr,         32'h00400004);
    check("seq1_valid",  32'(instrValid), 32'd1);
    check("seq1_ipc",    instrPc,         32'h00400000);
    check("seq1_instr",  instr,           32'h00400000 ^ DataKey);
    check("seq1_pc",     pc,              32'h00400004);
    cyc();
    check("seq2_addr", memAddr, 32'h00400008);
    check("seq2_ipc",  instrPc, 32'h00400004);

    // Stall holds the output register and blocks new requests
    stall = 1'b1;
    #1;
    check("stall_noreq", 32'(memReq), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_valid", 32'(instrValid), 32'd1);
      check("stall_ipc",   instrPc,         32'h00400004);
      check("stall_req",   32'(memReq),     32'd0);
    end
    check("stall_pc", pc, 32'h00400008);
    stall = 1'b0;
    #1;
    check("rel_req",  32'(memReq), 32'd1);
    check("rel_addr", memAddr,     32'h00400008);
    cyc();
    check("rel_ipc",   instrPc, 32'h00400008);
    check("rel_instr", instr,   32'h00400008 ^ DataKey);
    check("rel_addr2", memAddr, 32'h0040000C);

    // Branch while fetch of 0x0040000C awaits ack
    memAck = 1'b0;
    cyc();
    check("pend_req",   32'(memReq),     32'd1);
    check("pend_addr",  memAddr,         32'h0040000C);
    check("pend_valid", 32'(instrValid), 32'd0);
    redirectValid = 1'b1; action = 2'd1; branchTarget = 32'h00400100;
    cyc();
    check("br_flush", 32'(flush),      32'd1);
    check("br_pc",    pc,              32'h00400100);
    check("br_req",   32'(memReq),     32'd1);
    check("br_addr",  memAddr,         32'h0040000C);
    check("br_valid", 32'(instrValid), 32'd0);
    redirectValid = 1'b0; action = 2'd0;
    cyc();
    check("br_flush_once", 32'(flush),  32'd0);
    check("br_hold_req",   32'(memReq), 32'd1);
    check("br_hold_addr",  memAddr,     32'h0040000C);
    memAck = 1'b1;
    cyc();
    check("br_drop_valid", 32'(instrValid), 32'd0);
    check("br_tgt_addr",   memAddr,         32'h00400100);
    cyc();
    check("br_tgt_valid", 32'(instrValid), 32'd1);
    check("br_tgt_ipc",   instrPc,         32'h00400100);
    check("br_next_addr", memAddr,         32'h00400104);

    // JumpReg with misaligned target, acked in the same cycle
    redirectValid = 1'b1; action = 2'd3; regTarget = 32'h00400203;
    cyc();
    check("jr_flush", 32'(flush),      32'd1);
    check("jr_valid", 32'(instrValid), 32'd0);
    check("jr_pc",    pc,              32'h00400200);
    check("jr_addr",  memAddr,         32'h00400200);
    redirectValid = 1'b0; action = 2'd0;
    cyc();
    check("jr_flush_off", 32'(flush), 32'd0);
    check("jr_tgt_ipc",   instrPc,    32'h00400200);
    check("jr_next_addr", memAddr,    32'h00400204);

    // Redirect wins over stall; Inc with redirectValid is ignored
    stall = 1'b1; redirectValid = 1'b1; action = 2'd2; jumpTarget = 32'h00400300;
    #1;
    check("rs_noreq", 32'(memReq), 32'd0);
    cyc();
    check("rs_flush", 32'(flush),      32'd1);
    check("rs_valid", 32'(instrValid), 32'd0);
    check("rs_pc",    pc,              32'h00400300);
    stall = 1'b0; action = 2'd0;
    #1;
    check("inc_addr", memAddr, 32'h00400300);
    cyc();
    check("inc_flush", 32'(flush), 32'd0);
    check("inc_ipc",   instrPc,    32'h00400300);
    check("inc_pc",    pc,         32'h00400304);

    // Wrap at 2^32
    action = 2'd2; jumpTarget = 32'hFFFFFFFC;
    cyc();
    check("wr_valid", 32'(instrValid), 32'd0);
    check("wr_addr",  memAddr,         32'hFFFFFFFC);
    redirectValid = 1'b0; action = 2'd0;
    cyc();
    check("wr_ipc",  instrPc, 32'hFFFFFFFC);
    check("wr_pc",   pc,      32'h00000000);
    check("wr_addr2", memAddr, 32'h00000000);

    // Reset in the middle of DISCARD
    memAck = 1'b0; redirectValid = 1'b1; action = 2'd1; branchTarget = 32'h00400400;
    cyc();
    check("rd_flush", 32'(flush),  32'd1);
    check("rd_req",   32'(memReq), 32'd1);
    check("rd_addr",  memAddr,     32'h00000000);
    redirectValid = 1'b0; action = 2'd0; reset = 1'b1;
    cyc();
    check("rd_rst_req",   32'(memReq),     32'd0);
    check("rd_rst_valid", 32'(instrValid), 32'd0);
    check("rd_rst_flush", 32'(flush),      32'd0);
    check("rd_rst_instr", instr,           32'd0);
    check("rd_rst_ipc",   instrPc,         32'd0);
    check("rd_rst_pc",    pc,              32'h00400000);
    reset = 1'b0; memAck = 1'b1;
    cyc();
    check("post_rst_req",  32'(memReq), 32'd1);
    check("post_rst_addr", memAddr,     32'h00400000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
